// File: rtl/rbs_subtractor.sv
// rbs_subtractor: sequential ripple-borrow subtractor.
// Computes (a - b) mod 2^WIDTH one DATA_WIDTH-bit digit per clock, LSB first,
// carrying the borrow between digits. out_sub_result/out_borrow update only
// when the last digit completes and hold their value otherwise.
//
// Handshake: in_start is sampled on any rising edge where the block is not in
// RUN (IDLE or DONE); that edge captures the operands and begins the operation.
// out_busy is high for exactly N = WIDTH/DATA_WIDTH cycles. out_done pulses
// for one cycle on the cycle the new result becomes visible. A start held
// during the DONE cycle is accepted back-to-back.
module rbs_subtractor #(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_sub_a,
  input  logic [WIDTH-1:0] in_sub_b,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_sub_result,
  output logic             out_borrow,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DATA_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  logic [WIDTH-1:0]      res_q;
  logic [WIDTH-1:0]      res_nx;
  logic                  borrow_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] a_dig;
  logic [DATA_WIDTH-1:0] b_dig;
  logic [DATA_WIDTH:0]   diff;
  logic                  accept;
  logic                  last;

  assign accept    = in_start && (state != RUN);
  assign last      = (cnt == LAST_DIGIT);
  assign out_busy  = (state == RUN);
  assign out_done  = (state == DONE);
  assign dbg_state = state;

  // Current digit step: DATA_WIDTH+1-bit difference whose top bit is the new borrow.
  always_comb begin
    a_dig  = a_q[cnt*DATA_WIDTH +: DATA_WIDTH];
    b_dig  = b_q[cnt*DATA_WIDTH +: DATA_WIDTH];
    diff   = {1'b0, a_dig} - {1'b0, b_dig} - {{DATA_WIDTH{1'b0}}, borrow_q};
    res_nx = res_q;
    res_nx[cnt*DATA_WIDTH +: DATA_WIDTH] = diff[DATA_WIDTH-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = in_start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand capture, digit ripple and result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q            <= '0;
      b_q            <= '0;
      res_q          <= '0;
      borrow_q       <= 1'b0;
      cnt            <= '0;
      out_sub_result <= '0;
      out_borrow     <= 1'b0;
    end else if (accept) begin
      a_q      <= in_sub_a;
      b_q      <= in_sub_b;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (state == RUN) begin
      res_q    <= res_nx;
      borrow_q <= diff[DATA_WIDTH];
      cnt      <= cnt + 1'b1;
      if (last) begin
        out_sub_result <= res_nx;
        out_borrow     <= diff[DATA_WIDTH];
      end
    end
  end

endmodule

// File: doc/rbs_subtractor.md
# rbs_subtractor

Sequential ripple-borrow subtractor, the inverse-operation companion of the sequential ripple-carry adder. It computes a 32-bit unsigned difference one DATA_WIDTH-bit digit per clock, propagating the borrow between digits. A start/busy/done handshake wraps the operation. The block sits beside the adder in the sequential arithmetic datapath and is driven by the same operand-presenting logic.

## Interface
- WIDTH, 32: operand and result width in bits.
- DATA_WIDTH, 4: digit width processed per cycle. WIDTH must be an integer multiple of DATA_WIDTH. Legal values: 1, 2, 4, 8, 16, 32.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_start  input  1  request a new subtraction; sampled only when the block is not busy.
- in_sub_a  input  WIDTH  minuend, captured on the accepting edge.
- in_sub_b  input  WIDTH  subtrahend, captured on the accepting edge.
- out_busy  output  1  high while digits are being processed.
- out_done  output  1  one-cycle pulse; the result is valid from this cycle on.
- out_sub_result  output  WIDTH  (a − b) mod 2^WIDTH.
- out_borrow  output  1  final borrow out; 1 iff a < b (unsigned).

## Operation
- N = WIDTH/DATA_WIDTH digits. Default N = 8.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_start=1 → capture a and b into internal registers, clear the borrow, set the digit counter to 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle, compute digit i: d = a[i] − b[i] − borrow, using a DATA_WIDTH+1-bit signed intermediate.
  - Store d mod 2^DATA_WIDTH into internal result digit i.
  - The new borrow is 1 iff the intermediate is negative.
  - Increment the counter.
  - On the cycle that processes digit N−1: load the full result into out_sub_result, load the final borrow into out_borrow, go to DONE.
- DONE:
  - out_done=1 for this single cycle.
  - in_start=1 → accept a new operation exactly as in IDLE (back-to-back).
  - Otherwise go to IDLE.
- in_start is ignored in RUN. Operand inputs are don't-care after the accepting edge.
- out_sub_result and out_borrow change only at completion. They hold their value across IDLE and during any subsequent RUN.
- Digits are processed LSB-first. Digit i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- No internal signal ever exceeds DATA_WIDTH+1 bits per digit step.

## Timing
- Reset values: out_busy=0, out_done=0, out_sub_result=0, out_borrow=0, state IDLE, counter 0, internal borrow 0.
- Accepting edge E:
  - out_busy is high from edge E to edge E+N, i.e. exactly N cycles.
  - out_done and the new result appear at edge E+N.
  - out_done falls at E+N+1.
- Latency from start to done is N cycles (default 8). For DATA_WIDTH=WIDTH, latency is 1 cycle and out_busy is high for 1 cycle.
- Back-to-back throughput: a start held high in the DONE cycle is accepted at E+N+1. The next done follows N+1 cycles after the previous done.
- Reset asserted in any state, including mid-RUN:
  - All outputs return to reset values on the next edge.
  - The aborted operation never pulses out_done.
  - in_start during reset is ignored.
- Borrow wrap-around: a = 0, b ≠ 0 produces a borrow out of digit N−1 → out_borrow=1 and the result wraps modulo 2^WIDTH.

## Test plan
- Reset held 10 cycles with in_start=1 and random operands → all outputs 0 throughout, no out_done; after release with start low, the block stays IDLE.
- a=0x0000_0010, b=0x0000_0001, start at edge E → out_busy high 8 cycles, out_done pulse at E+8, result 0x0000_000F, borrow 0.
- a=0x0000_0000, b=0x0000_0001 → result 0xFFFF_FFFF, borrow 1; checks that the borrow ripples across all 8 digits.
- a=0x8000_0000, b=0x8000_0000, then during RUN pulse start with a=7, b=9 and change the operand inputs → ignored; result 0x0000_0000, borrow 0, single done pulse.
- Back-to-back: a=5, b=3, then start held in the DONE cycle with a=3, b=5 → first done result 0x0000_0002/0; second done 9 cycles later with 0xFFFF_FFFE/1.
- Reset asserted on the 4th RUN cycle of a=0x1234_5678, b=0x0000_0001 → no done, outputs 0. A following a=0x1234_5678, b=0x0000_0001 run completes normally with result 0x1234_5677, borrow 0.
